core_l1i: RTL and testbench

Direct-mapped L1 instruction cache sitting directly downstream of the core's instruction request interface (i_req_val / i_req_addr / i_req_ack / i_ack_rdata). It serves fetches from a local array on a hit. On a miss it refills a whole line from the memory side, one word per handshake. Addresses inside the CSR-programmed non-cacheable window bypass the array as single-word reads.

---
 rtl/core_l1i_pkg.sv | 30 +++
 rtl/core_l1i_array.sv | 54 +++++
 rtl/core_l1i.sv | 155 +++++++++++++++
 tb/tb_core_l1i.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_l1i_pkg.sv
// Shared types, default geometry and address helpers for the direct-mapped L1 instruction cache.
package core_l1i_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        NC_RD,
        RESP
    } state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 64;

    localparam int OFFSET_W = $clog2(DEF_LINE_WORDS);
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int TAG_W    = DEF_ADDR_WIDTH - OFFSET_W - INDEX_W - 2;

    // Generic bit-field pick; callers size the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lo, input int w);
        return (addr >> lo) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic nc_hit(input logic [63:0] addr, input logic [63:0] base,
                                    input logic [63:0] mask);
        return ((addr & ~mask) == base);
    endfunction

endpackage

// File: rtl/core_l1i_array.sv
// Tag, data and valid storage for the L1I; only the valid bits are reset.
module core_l1i_array #(
    parameter  int LINE_WORDS = 4,
    parameter  int NUM_LINES  = 64,
    parameter  int TAG_W      = 22,
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int IDX_W      = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_index,
    input  logic [OFF_W-1:0] i_wr_offset,
    input  logic [31:0]      i_wr_data,
    input  logic             i_tag_wr,
    input  logic             i_tag_valid,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_clr_all,
    input  logic [IDX_W-1:0] i_rd_index,
    input  logic [OFF_W-1:0] i_rd_offset,
    output logic [31:0]      o_rd_data,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic             o_rd_valid
);

    logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
        end
        if (i_tag_wr) begin
            r_tag[i_wr_index] <= i_tag;
        end
    end

    // A global clear beats a simultaneous tag write so an invalidate is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr_all) begin
            r_valid <= '0;
        end else if (i_tag_wr) begin
            r_valid[i_wr_index] <= i_tag_valid;
        end
    end

    assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];

endmodule

// File: rtl/core_l1i.sv
// Direct-mapped L1 instruction cache: hit service, whole-line refill and a non-cacheable bypass window.
module core_l1i
    import core_l1i_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_val,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ack,
    output logic [31:0]           i_ack_rdata,
    input  logic [ADDR_WIDTH-1:0] ncache_base,
    input  logic [ADDR_WIDTH-1:0] ncache_mask,
    input  logic                  inv_all,
    output logic                  mem_req_val,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ack,
    input  logic [31:0]           mem_ack_rdata
);

    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_WIDTH - OFF_W - IDX_W - 2;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [OFF_W-1:0]      r_cnt;
    logic [31:0]           r_data;
    logic                  r_inv_pend;

    logic [OFF_W-1:0]      w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_nc;
    logic                  w_hit;
    logic                  w_wr_en;
    logic                  w_last;
    logic                  w_clr_all;
    logic [31:0]           w_rd_data;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic                  w_rd_valid;

    assign w_off = OFF_W'(addr_field(64'(r_addr), 2, OFF_W));
    assign w_idx = IDX_W'(addr_field(64'(r_addr), OFF_W + 2, IDX_W));
    assign w_tag = TAG_BITS'(addr_field(64'(r_addr), OFF_W + IDX_W + 2, TAG_BITS));
    assign w_nc  = nc_hit(64'(r_addr), 64'(ncache_base), 64'(ncache_mask));
    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    assign w_wr_en = (r_state == REFILL) && mem_req_ack;
    assign w_last  = (r_cnt == OFF_W'(LINE_WORDS - 1));
    // Invalidates seen mid-transaction are deferred and applied as the FSM heads back to IDLE.
    assign w_clr_all = (inv_all && (r_state == IDLE || r_state == LOOKUP)) ||
                       ((r_state == RESP) && (r_inv_pend || inv_all));

    core_l1i_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_BITS)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_idx),
        .i_wr_offset (r_cnt),
        .i_wr_data   (mem_ack_rdata),
        .i_tag_wr    (w_wr_en && w_last),
        .i_tag_valid (!(r_inv_pend || inv_all)),
        .i_tag       (w_tag),
        .i_clr_all   (w_clr_all),
        .i_rd_index  (w_idx),
        .i_rd_offset (w_off),
        .o_rd_data   (w_rd_data),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        i_req_ack   = 1'b0;
        i_ack_rdata = '0;
        case (r_state)
            IDLE:   if (i_req_val) w_next = LOOKUP;
            LOOKUP: begin
                if (w_hit) begin
                    i_req_ack   = 1'b1;
                    i_ack_rdata = w_rd_data;
                    w_next      = IDLE;
                end else if (w_nc) begin
                    w_next = NC_RD;
                end else begin
                    w_next = REFILL;
                end
            end
            REFILL: if (mem_req_ack && w_last) w_next = RESP;
            NC_RD:  if (mem_req_ack) w_next = RESP;
            RESP: begin
                i_req_ack   = 1'b1;
                i_ack_rdata = r_data;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The requested word is captured as it streams past, so RESP never re-reads the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_inv_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_req_val) r_addr <= i_req_addr;
                LOOKUP: begin
                    r_cnt <= '0;
                    if (!w_hit) begin
                        r_mem_addr <= w_nc ? {r_addr[ADDR_WIDTH-1:2], 2'b00}
                                           : {r_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                    end
                end
                REFILL: if (mem_req_ack) begin
                    r_cnt      <= r_cnt + OFF_W'(1);
                    r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
                    if (r_cnt == w_off) r_data <= mem_ack_rdata;
                end
                NC_RD: if (mem_req_ack) r_data <= mem_ack_rdata;
                default: ;
            endcase
            if (r_state == RESP) begin
                r_inv_pend <= 1'b0;
            end else if (inv_all && (r_state == REFILL || r_state == NC_RD)) begin
                r_inv_pend <= 1'b1;
            end
        end
    end

    assign mem_req_val  = (r_state == REFILL) || (r_state == NC_RD);
    assign mem_req_addr = r_mem_addr;

endmodule

// File: tb/tb_core_l1i.sv
// Self-checking bench for core_l1i: directed cache scenarios then random fetches against a line-level model.
module tb_core_l1i;
    import core_l1i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        reqVal;
    logic [31:0] reqAddr;
    logic        reqAck;
    logic [31:0] ackRdata;
    logic [31:0] ncBase;
    logic [31:0] ncMask;
    logic        invAll;
    logic        memReqVal;
    logic [31:0] memReqAddr;
    logic        memReqAck;
    logic [31:0] memAckRdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] memOverride [logic [31:0]];
    logic [31:0] memSeed;
    logic [31:0] memLog [$];
    int          fixedWait = 2;
    int          curWait   = 2;
    int          waitCnt   = 0;

    bit          mv [DEF_NUM_LINES];
    logic [31:0] mt [DEF_NUM_LINES];

    core_l1i u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_val     (reqVal),
        .i_req_addr    (reqAddr),
        .i_req_ack     (reqAck),
        .i_ack_rdata   (ackRdata),
        .ncache_base   (ncBase),
        .ncache_mask   (ncMask),
        .inv_all       (invAll),
        .mem_req_val   (memReqVal),
        .mem_req_addr  (memReqAddr),
        .mem_req_ack   (memReqAck),
        .mem_ack_rdata (memAckRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (memOverride.exists(a)) return memOverride[a];
        return (a * 32'h9E37_79B9) ^ memSeed;
    endfunction

    // Memory responder: acks each beat after curWait idle cycles and logs the address served.
    initial begin
        memReqAck   = 1'b0;
        memAckRdata = '0;
        forever begin
            @(negedge clk);
            memReqAck = 1'b0;
            if (memReqVal && rst_n) begin
                if (waitCnt < curWait) begin
                    waitCnt++;
                end else begin
                    memReqAck   = 1'b1;
                    memAckRdata = memWord(memReqAddr);
                    memLog.push_back(memReqAddr);
                    waitCnt = 0;
                    curWait = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelClearAll();
        for (int i = 0; i < DEF_NUM_LINES; i++) mv[i] = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, output logic [31:0] d, output int lat,
                                 output bit to, output bit valAtAck);
        d = '0; lat = 0; to = 1'b1; valAtAck = 1'b0;
        @(posedge clk); #1;
        reqVal  = 1'b1;
        reqAddr = a;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            lat++;
            if (reqAck) begin
                d        = ackRdata;
                valAtAck = memReqVal;
                to       = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        reqVal = 1'b0;
    endtask

    task automatic pulseInvOnBeat();
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (memLog.size() >= 1) seen = 1'b1;
        end
        checkOutput("invBeatWait", 32'(seen), 32'd1);
        @(posedge clk); #1 invAll = 1'b1;
        @(posedge clk); #1 invAll = 1'b0;
    endtask

    task automatic pulseInvIdle();
        @(posedge clk); #1 invAll = 1'b1;
        @(posedge clk); #1 invAll = 1'b0;
        modelClearAll();
    endtask

    task automatic doFetch(input logic [31:0] a, input bit invMid);
        logic [31:0] d, tg, base;
        int lat, idx;
        bit to, valAtAck, hit, nc;
        idx  = int'((a >> (OFFSET_W + 2)) & 32'(DEF_NUM_LINES - 1));
        tg   = a >> (OFFSET_W + INDEX_W + 2);
        hit  = mv[idx] && (mt[idx] == tg);
        nc   = ((a & ~ncMask) == ncBase);
        base = a & ~32'((DEF_LINE_WORDS * 4) - 1);
        memLog.delete();
        fork
            applyStimulus(a, d, lat, to, valAtAck);
            if (invMid) pulseInvOnBeat();
        join
        checkOutput($sformatf("timeout@%h", a), 32'(to), 32'd0);
        checkOutput($sformatf("rdata@%h", a), d, memWord({a[31:2], 2'b00}));
        checkOutput($sformatf("memValInResp@%h", a), 32'(valAtAck), 32'd0);
        if (hit) begin
            checkOutput($sformatf("hitLatency@%h", a), 32'(lat), 32'd2);
            checkOutput($sformatf("hitReads@%h", a), 32'(memLog.size()), 32'd0);
        end else if (nc) begin
            checkOutput($sformatf("ncReads@%h", a), 32'(memLog.size()), 32'd1);
            if (memLog.size() >= 1) checkOutput($sformatf("ncAddr@%h", a), memLog[0], {a[31:2], 2'b00});
        end else begin
            checkOutput($sformatf("refillReads@%h", a), 32'(memLog.size()), 32'(DEF_LINE_WORDS));
            for (int i = 0; i < memLog.size() && i < DEF_LINE_WORDS; i++) begin
                checkOutput($sformatf("refillAddr%0d@%h", i, a), memLog[i], base + 32'(4 * i));
            end
            if (invMid) begin
                modelClearAll();
            end else begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        bit seen;
        rst_n   = 1'b0;
        reqVal  = 1'b0;
        reqAddr = '0;
        ncBase  = 32'hFFFF_FFFF;
        ncMask  = 32'h0000_0000;
        invAll  = 1'b0;
        memSeed = $urandom;
        for (int i = 0; i < 4; i++) memOverride[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        modelClearAll();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReqAck", 32'(reqAck), 32'd0);
        checkOutput("rstAckRdata", ackRdata, 32'd0);
        checkOutput("rstMemVal", 32'(memReqVal), 32'd0);
        checkOutput("rstMemAddr", memReqAddr, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("[TB] cold miss, hit, non-cacheable window");
        doFetch(32'h0000_0100, 1'b0);
        doFetch(32'h0000_0108, 1'b0);
        ncBase = 32'h8000_0000;
        ncMask = 32'h0000_FFFF;
        doFetch(32'h8000_0010, 1'b0);
        doFetch(32'h8000_0010, 1'b0);
        doFetch(32'h0000_0108, 1'b0);

        $display("[TB] conflict misses on index 16");
        doFetch(32'h0000_0100, 1'b0);
        doFetch(32'h0000_0500, 1'b0);
        doFetch(32'h0000_0100, 1'b0);

        $display("[TB] invalidate during refill and in idle");
        doFetch(32'h0000_0200, 1'b1);
        doFetch(32'h0000_0200, 1'b0);
        doFetch(32'h0000_0100, 1'b0);
        pulseInvIdle();
        doFetch(32'h0000_0100, 1'b0);

        $display("[TB] reset during refill beat 3");
        pulseInvIdle();
        memLog.delete();
        @(posedge clk); #1;
        reqVal  = 1'b1;
        reqAddr = 32'h0000_0100;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (memLog.size() >= 2) seen = 1'b1;
        end
        checkOutput("rstBeatWait", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst_n  = 1'b0;
        reqVal = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midRstMemVal", 32'(memReqVal), 32'd0);
        checkOutput("midRstReqAck", 32'(reqAck), 32'd0);
        modelClearAll();
        doFetch(32'h0000_0100, 1'b0);

        $display("[TB] random fetches");
        fixedWait = -1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) pulseInvIdle();
            if ($urandom_range(0, 5) == 0) begin
                ra = 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2);
            end else begin
                ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(14, 17)) << 4) |
                     (32'($urandom_range(0, 3)) << 2);
            end
            doFetch(ra, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
